serial_subtractor: RTL and testbench

//   Bit-serial WIDTH-bit subtractor, the borrow-chain counterpart of the

---
 rtl/serial_subtractor_if.sv | 27 ++
 rtl/serial_subtractor.sv | 115 +++++++++++
 tb/tb_serial_subtractor.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Request/response bundle for the bit-serial subtractor.
// The master drives requests and result-ready; the slave (the subtractor) drives the rest.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start_valid_i;
  logic             start_ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             bin_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] diff_o;
  logic             bout_o;
  logic             ovf_o;
  logic             busy_o;

  modport master (
    output start_valid_i, a_i, b_i, bin_i, ready_i,
    input  start_ready_o, valid_o, diff_o, bout_o, ovf_o, busy_o
  );

  modport slave (
    input  start_valid_i, a_i, b_i, bin_i, ready_i,
    output start_ready_o, valid_o, diff_o, bout_o, ovf_o, busy_o
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Operands are shifted right through a single full-subtractor cell; result bits
// enter the working register from the MSB end so the full word is aligned once
// the last bit has been processed.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input logic                 clk_i,
  input logic                 reset_n_i,
  serial_subtractor_if.slave  bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  state_e           state;
  logic [CntW-1:0]  count;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] work;
  logic             brw;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             start_ready;
  logic             valid;
  logic             busy;

  logic a_bit;
  logic b_bit;
  logic d_bit;
  logic brw_next;

  // Full-subtractor cell on the current bit position.
  assign a_bit    = a_sh[0];
  assign b_bit    = b_sh[0];
  assign d_bit    = a_bit ^ b_bit ^ brw;
  assign brw_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & brw);

  // FSM with datapath; status flags are registered alongside the state.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state       <= StIdle;
      count       <= '0;
      a_sh        <= '0;
      b_sh        <= '0;
      work        <= '0;
      brw         <= 1'b0;
      diff        <= '0;
      bout        <= 1'b0;
      ovf         <= 1'b0;
      start_ready <= 1'b1;
      valid       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (bus.start_valid_i) begin
            a_sh        <= bus.a_i;
            b_sh        <= bus.b_i;
            brw         <= bus.bin_i;
            count       <= '0;
            state       <= StBusy;
            start_ready <= 1'b0;
            busy        <= 1'b1;
          end
        end
        StBusy: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          work <= {d_bit, work[WIDTH-1:1]};
          brw  <= brw_next;
          if (count == LastCnt) begin
            // On the last bit a_bit/b_bit/d_bit are the sign bits of a, b and diff.
            diff  <= {d_bit, work[WIDTH-1:1]};
            bout  <= brw_next;
            ovf   <= (a_bit ^ b_bit) & (d_bit ^ a_bit);
            state <= StDone;
            busy  <= 1'b0;
            valid <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end
        StDone: begin
          if (bus.ready_i) begin
            state       <= StIdle;
            valid       <= 1'b0;
            start_ready <= 1'b1;
          end
        end
        default: begin
          state       <= StIdle;
          valid       <= 1'b0;
          busy        <= 1'b0;
          start_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.start_ready_o = start_ready;
  assign bus.valid_o       = valid;
  assign bus.busy_o        = busy;
  assign bus.diff_o        = diff;
  assign bus.bout_o        = bout;
  assign bus.ovf_o         = ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector and randomized bench for serial_subtractor at WIDTH 8 and 32.
module tb_serial_subtractor;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
  } vec_t;

  typedef struct {
    logic [63:0] diff;
    logic        bout;
    logic        ovf;
  } exp_t;

  logic clk;
  logic reset_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  serial_subtractor_if #(.WIDTH(8))  bus8 ();
  serial_subtractor_if #(.WIDTH(32)) bus32 ();

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .bus       (bus8)
  );

  serial_subtractor #(.WIDTH(32)) dut32 (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .bus       (bus32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One 8-bit operation with ready_i held high; returns result and accept-to-valid edges.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                         output logic [7:0] d, output logic bo, output logic ov,
                         output int lat);
    check("op8 start_ready", bus8.start_ready_o, 1);
    bus8.a_i = a;
    bus8.b_i = b;
    bus8.bin_i = bin;
    bus8.start_valid_i = 1'b1;
    @(posedge clk); #1;
    bus8.start_valid_i = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (bus8.valid_o) break;
    end
    d  = bus8.diff_o;
    bo = bus8.bout_o;
    ov = bus8.ovf_o;
    @(posedge clk); #1;
  endtask

  vec_t       vecs[10];
  exp_t       q[$];
  exp_t       e;
  logic [7:0] d8;
  logic       bo8;
  logic       ov8;
  int         lat;

  initial begin
    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0};
    vecs[7] = '{8'h00, 8'h80, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[8] = '{8'h7F, 8'h00, 1'b1, 8'h7E, 1'b0, 1'b0};
    vecs[9] = '{8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1};

    bus8.start_valid_i = 1'b0;
    bus8.a_i = '0;
    bus8.b_i = '0;
    bus8.bin_i = 1'b0;
    bus8.ready_i = 1'b0;
    bus32.start_valid_i = 1'b0;
    bus32.a_i = '0;
    bus32.b_i = '0;
    bus32.bin_i = 1'b0;
    bus32.ready_i = 1'b0;
    reset_n = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst valid", bus8.valid_o, 0);
    check("rst busy", bus8.busy_o, 0);
    check("rst diff", bus8.diff_o, 0);
    check("rst bout", bus8.bout_o, 0);
    check("rst ovf", bus8.ovf_o, 0);
    check("rst start_ready", bus8.start_ready_o, 1);
    check("rst32 start_ready", bus32.start_ready_o, 1);
    check("rst32 diff", bus32.diff_o, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors
    bus8.ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      run_op8(vecs[i].a, vecs[i].b, vecs[i].bin, d8, bo8, ov8, lat);
      check($sformatf("vec%0d diff", i), d8, vecs[i].diff);
      check($sformatf("vec%0d bout", i), bo8, vecs[i].bout);
      check($sformatf("vec%0d ovf", i), ov8, vecs[i].ovf);
      check($sformatf("vec%0d latency", i), lat, 8);
      check($sformatf("vec%0d back idle", i), bus8.start_ready_o, 1);
    end

    // Backpressure in DONE: outputs hold, requests ignored
    bus8.ready_i = 1'b0;
    bus8.a_i = 8'h3C;
    bus8.b_i = 8'h0F;
    bus8.bin_i = 1'b0;
    bus8.start_valid_i = 1'b1;
    @(posedge clk); #1;
    bus8.start_valid_i = 1'b0;
    check("hold busy", bus8.busy_o, 1);
    check("hold busy no start_ready", bus8.start_ready_o, 0);
    lat = 0;
    while (!bus8.valid_o && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("hold latency", lat, 8);
    for (int i = 0; i < 5; i++) begin
      bus8.start_valid_i = 1'b0;
      check($sformatf("hold%0d valid", i), bus8.valid_o, 1);
      check($sformatf("hold%0d diff", i), bus8.diff_o, 8'h2D);
      check($sformatf("hold%0d bout", i), bus8.bout_o, 0);
      check($sformatf("hold%0d start_ready", i), bus8.start_ready_o, 0);
      if (i == 2) begin
        bus8.a_i = 8'h11;
        bus8.b_i = 8'h22;
        bus8.start_valid_i = 1'b1;
      end
      @(posedge clk); #1;
    end
    bus8.start_valid_i = 1'b0;
    bus8.ready_i = 1'b1;
    @(posedge clk); #1;
    check("release valid", bus8.valid_o, 0);
    check("release start_ready", bus8.start_ready_o, 1);
    check("release busy", bus8.busy_o, 0);
    check("release diff held", bus8.diff_o, 8'h2D);

    // Asynchronous reset mid-operation
    bus8.a_i = 8'hAA;
    bus8.b_i = 8'h55;
    bus8.bin_i = 1'b0;
    bus8.start_valid_i = 1'b1;
    @(posedge clk); #1;
    bus8.start_valid_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midop busy", bus8.busy_o, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async rst busy", bus8.busy_o, 0);
    check("async rst valid", bus8.valid_o, 0);
    check("async rst start_ready", bus8.start_ready_o, 1);
    check("async rst diff", bus8.diff_o, 0);
    check("async rst ovf", bus8.ovf_o, 0);
    @(posedge clk); #1;
    check("in rst no result", bus8.valid_o, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_op8(8'h10, 8'h01, 1'b0, d8, bo8, ov8, lat);
    check("post rst diff", d8, 8'h0F);
    check("post rst bout", bo8, 0);
    check("post rst latency", lat, 8);

    // Random traffic with backpressure, WIDTH 8
    begin
      int acc = 0;
      int cyc = 0;
      logic [8:0] r9;
      bus8.ready_i = 1'b0;
      while ((acc < 1500 || q.size() > 0) && cyc < 40000) begin
        @(negedge clk);
        cyc++;
        bus8.start_valid_i = (acc < 1500) ? 1'($urandom_range(0, 1)) : 1'b0;
        bus8.a_i = 8'($urandom);
        bus8.b_i = 8'($urandom);
        bus8.bin_i = 1'($urandom_range(0, 1));
        bus8.ready_i = 1'($urandom_range(0, 1));
        if (bus8.start_ready_o && bus8.start_valid_i) begin
          r9 = {1'b0, bus8.a_i} - {1'b0, bus8.b_i} - {8'd0, bus8.bin_i};
          e.diff = {56'd0, r9[7:0]};
          e.bout = r9[8];
          e.ovf = (bus8.a_i[7] != bus8.b_i[7]) && (r9[7] != bus8.a_i[7]);
          q.push_back(e);
          acc++;
        end
        if (bus8.valid_o && bus8.ready_i) begin
          if (q.size() == 0) begin
            check("rnd8 unexpected result", 1, 0);
          end else begin
            e = q.pop_front();
            check("rnd8 diff", bus8.diff_o, e.diff);
            check("rnd8 bout", bus8.bout_o, e.bout);
            check("rnd8 ovf", bus8.ovf_o, e.ovf);
          end
        end
      end
      bus8.start_valid_i = 1'b0;
      check("rnd8 all done", (acc >= 1500 && q.size() == 0) ? 1 : 0, 1);
    end

    // Random traffic with backpressure, WIDTH 32
    begin
      int acc = 0;
      int cyc = 0;
      logic [32:0] r33;
      q.delete();
      bus32.ready_i = 1'b0;
      while ((acc < 400 || q.size() > 0) && cyc < 40000) begin
        @(negedge clk);
        cyc++;
        bus32.start_valid_i = (acc < 400) ? 1'($urandom_range(0, 1)) : 1'b0;
        bus32.a_i = $urandom;
        bus32.b_i = $urandom;
        bus32.bin_i = 1'($urandom_range(0, 1));
        bus32.ready_i = 1'($urandom_range(0, 1));
        if (bus32.start_ready_o && bus32.start_valid_i) begin
          r33 = {1'b0, bus32.a_i} - {1'b0, bus32.b_i} - {32'd0, bus32.bin_i};
          e.diff = {32'd0, r33[31:0]};
          e.bout = r33[32];
          e.ovf = (bus32.a_i[31] != bus32.b_i[31]) && (r33[31] != bus32.a_i[31]);
          q.push_back(e);
          acc++;
        end
        if (bus32.valid_o && bus32.ready_i) begin
          if (q.size() == 0) begin
            check("rnd32 unexpected result", 1, 0);
          end else begin
            e = q.pop_front();
            check("rnd32 diff", bus32.diff_o, e.diff);
            check("rnd32 bout", bus32.bout_o, e.bout);
            check("rnd32 ovf", bus32.ovf_o, e.ovf);
          end
        end
      end
      bus32.start_valid_i = 1'b0;
      check("rnd32 all done", (acc >= 400 && q.size() == 0) ? 1 : 0, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
